p0008_stream: RTL and testbench
===============================

// Module: p0008_stream
// PURPOSE
//   Streaming, parametrised largest-product-in-a-series engine (Euler #8 generalised).
//   Accepts decimal digits over a valid/ready handshake instead of a hard-coded string.
//   Keeps the maximum product of WINDOW adjacent digits and the 0-based start index of that window.
//   Sits between a digit source (ROM reader or testbench) and the result/compare logic.
// PARAMETERS
//   WINDOW    13  number of adjacent digits per product (>=1)
//   RESULT_W  46  product/result width; must be >= ceil(WINDOW*log2(9))
//   IDX_W     16  digit index and best_index width
// PORTS
//   clk          in   1         clock, rising edge
//   rst          in   1         asynchronous, active-high reset
//   start        in   1         1-cycle pulse; begins a new series (honoured in IDLE/DONE only)
//   digit_valid  in   1         digit/digit_last valid
//   digit        in   4         decimal digit 0..9
//   digit_last   in   1         marks final digit of the series
//   digit_ready  out  1         engine accepts a digit this cycle
//   busy         out  1         high in ACCEPT or MUL
//   result       out  RESULT_W  largest WINDOW-digit product so far
//   best_index   out  IDX_W     0-based index of first digit of the best window
//   done         out  1         series finished; held until start or rst
//   error        out  1         non-digit input, short series or index overflow; valid with done
// BEHAVIOUR
//   Reset: all outputs 0, window register 0, counters 0, state IDLE. Applies mid-operation.
//   States: IDLE, ACCEPT, MUL, DONE.
//   IDLE/DONE: digit_ready=0. On start: result, best_index, done, error, digit count and index
//     cleared; next state ACCEPT. Other inputs ignored. start in ACCEPT/MUL is ignored.
//   ACCEPT: digit_ready=1. Handshake = digit_valid & digit_ready.
//     digit>9: error=1, done=1 -> DONE; digit is discarded.
//     Otherwise shift digit into WINDOW-deep window register (newest at slot 0), increment index,
//       fill count saturates at WINDOW.
//     Fill count reaches WINDOW: acc=1, j=0 -> MUL.
//     Fill count < WINDOW and digit_last: error=1, done=1, result stays 0 -> DONE.
//     Index would exceed 2^IDX_W-1: error=1, done=1 -> DONE.
//   MUL: exactly WINDOW cycles, acc <= acc*window[j] truncated to RESULT_W; no zero early-exit.
//     Last cycle: if product > result (strict), result <= product and best_index <= index-WINDOW.
//     Ties keep the earliest window.
//     Then DONE (done=1, error=0) if the triggering digit had digit_last, else ACCEPT.
//     digit_ready=0 throughout MUL.
//   Throughput: once the window is full, 1 accept cycle + WINDOW MUL cycles per digit.
//     Before the window fills, one digit per cycle.
//   result/best_index update only at MUL end; stable in DONE.
//   done rises the cycle after the terminating event; busy=0 in DONE.
// TESTING
//   1 WINDOW=4; stream 1,2,3,4,5,0,9,9(last)
//     -> products 24,120,0,0,0; result=120, best_index=1, done=1, error=0.
//   2 WINDOW=13, RESULT_W=46; 1000-digit Euler #8 series
//     -> result=23514624000, error=0; completion in 1000+988*13 cycles after start (+/-2).
//   3 WINDOW=4; stream 7,7,4'hA -> error=1, done=1, result=0; later start + valid series succeeds.
//   4 WINDOW=4; stream 9,9,9(last) -> error=1, done=1, result=0, best_index=0.
//   5 WINDOW=2; stream 2,3,1,6(last) -> products 6,3,6; result=6, best_index=0 (tie keeps first).
//   6 WINDOW=4; assert rst during MUL -> all outputs 0 immediately; digit_ready never 1 during MUL;
//     start after rst release reruns test 1 correctly.

Source files
------------

// File: rtl/p0008_stream_if.sv
// rtl/p0008_stream_if.sv - digit stream handshake bundle for p0008_stream
// Purpose: groups the digit source -> engine valid/ready stream.
// Signals:
//   digit_valid  source -> engine  digit/digit_last are valid
//   digit        source -> engine  decimal digit 0..9 (values above 9 are flagged)
//   digit_last   source -> engine  final digit of the series
//   digit_ready  engine -> source  engine accepts a digit this cycle
interface p0008_stream_if;
   logic       digit_valid;
   logic [3:0] digit;
   logic       digit_last;
   logic       digit_ready;

   modport master (
      output digit_valid,
      output digit,
      output digit_last,
      input  digit_ready
   );

   modport slave (
      input  digit_valid,
      input  digit,
      input  digit_last,
      output digit_ready
   );
endinterface

// File: rtl/p0008_stream.sv
// rtl/p0008_stream.sv - streaming largest product of WINDOW adjacent digits
// Purpose: accepts a decimal digit series, tracks the maximum product of any
//   WINDOW adjacent digits and the 0-based start index of that window.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   start        pulse; begins a new series from IDLE or DONE
//   ds           digit stream (slave side of p0008_stream_if)
//   busy         high while accepting digits or multiplying
//   result       largest WINDOW-digit product seen so far
//   best_index   start index of the window that produced result
//   done         series finished; held until start or rst
//   error        non-digit, short series or index overflow; valid with done
module p0008_stream #(
   parameter int WINDOW   = 13,
   parameter int RESULT_W = 46,
   parameter int IDX_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   p0008_stream_if.slave       ds,
   output logic                busy,
   output logic [RESULT_W-1:0] result,
   output logic [IDX_W-1:0]    best_index,
   output logic                done,
   output logic                error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_MUL,
      S_DONE
   } state_t;

   localparam int FW = $clog2(WINDOW + 1);
   localparam int JW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [FW-1:0]    FILL_MAX = FW'(WINDOW);
   localparam logic [JW-1:0]    J_LAST   = JW'(WINDOW - 1);
   localparam logic [IDX_W-1:0] IDX_MAX  = '1;

   state_t              state, state_nx;
   logic [3:0]          win [WINDOW];   // newest digit in slot 0
   logic [FW-1:0]       fill;
   logic [FW-1:0]       fill_nx;
   logic [IDX_W-1:0]    idx;            // number of digits accepted so far
   logic [JW-1:0]       j;
   logic [RESULT_W-1:0] acc;
   logic [RESULT_W-1:0] prod;
   logic                last_q;         // the digit that started this MUL closed the series
   logic                ready_c;
   logic                hs;
   logic                bad_digit;
   logic                idx_ovf;
   logic                win_full_nx;
   logic                mul_last;

   assign hs          = ds.digit_valid && (state == S_ACCEPT);
   assign bad_digit   = ds.digit > 4'd9;
   assign idx_ovf     = (idx == IDX_MAX);
   assign fill_nx     = (fill == FILL_MAX) ? fill : fill + 1'b1;
   assign win_full_nx = (fill_nx == FILL_MAX);
   assign mul_last    = (j == J_LAST);
   // one window slot per MUL cycle; the order of factors does not matter
   assign prod        = acc * RESULT_W'(win[j]);
   assign ds.digit_ready = ready_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ready_c  = 1'b0;
      busy     = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nx = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            ready_c = 1'b1;
            busy    = 1'b1;
            if (hs) begin
               if (bad_digit || idx_ovf) begin
                  state_nx = S_DONE;
               end else if (win_full_nx) begin
                  state_nx = S_MUL;
               end else if (ds.digit_last) begin
                  state_nx = S_DONE;
               end
            end
         end
         S_MUL: begin
            busy = 1'b1;
            if (mul_last) begin
               state_nx = last_q ? S_DONE : S_ACCEPT;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WINDOW; i++) begin
            win[i] <= '0;
         end
         fill       <= '0;
         idx        <= '0;
         j          <= '0;
         acc        <= '0;
         last_q     <= 1'b0;
         result     <= '0;
         best_index <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  for (int i = 0; i < WINDOW; i++) begin
                     win[i] <= '0;
                  end
                  fill       <= '0;
                  idx        <= '0;
                  j          <= '0;
                  acc        <= '0;
                  last_q     <= 1'b0;
                  result     <= '0;
                  best_index <= '0;
                  done       <= 1'b0;
                  error      <= 1'b0;
               end
            end
            S_ACCEPT: begin
               if (hs) begin
                  if (bad_digit || idx_ovf) begin
                     // offending digit is dropped; result keeps its last value
                     error <= 1'b1;
                     done  <= 1'b1;
                  end else begin
                     win[0] <= ds.digit;
                     for (int i = 1; i < WINDOW; i++) begin
                        win[i] <= win[i-1];
                     end
                     idx  <= idx + 1'b1;
                     fill <= fill_nx;
                     if (win_full_nx) begin
                        acc    <= RESULT_W'(1);
                        j      <= '0;
                        last_q <= ds.digit_last;
                     end else if (ds.digit_last) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            S_MUL: begin
               acc <= prod;
               if (!mul_last) begin
                  j <= j + 1'b1;
               end else begin
                  // strict compare: ties keep the earliest window
                  if (prod > result) begin
                     result     <= prod;
                     best_index <= idx - IDX_W'(WINDOW);
                  end
                  if (last_q) begin
                     done  <= 1'b1;
                     error <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_p0008_stream.sv
// tb/tb_p0008_stream.sv - scoreboard bench for p0008_stream (WINDOW 4, 13, 2)
module tb_p0008_stream;

   typedef struct {
      longint res;
      longint idx;
      longint err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       src_valid = 1'b0;
   logic [3:0] src_digit = 4'd0;
   logic       src_last = 1'b0;
   int         sel = 0;

   always #5 clk = ~clk;

   p0008_stream_if if4 ();
   p0008_stream_if if13 ();
   p0008_stream_if if2 ();

   assign if4.digit_valid  = src_valid && (sel == 0);
   assign if13.digit_valid = src_valid && (sel == 1);
   assign if2.digit_valid  = src_valid && (sel == 2);
   assign if4.digit  = src_digit;
   assign if13.digit = src_digit;
   assign if2.digit  = src_digit;
   assign if4.digit_last  = src_last;
   assign if13.digit_last = src_last;
   assign if2.digit_last  = src_last;

   logic st4, st13, st2;
   assign st4  = start && (sel == 0);
   assign st13 = start && (sel == 1);
   assign st2  = start && (sel == 2);

   logic        busy4, busy13, busy2, done4, done13, done2, err4, err13, err2;
   logic [45:0] res4, res13, res2;
   logic [15:0] bi4, bi13, bi2;

   p0008_stream #(.WINDOW(4), .RESULT_W(46), .IDX_W(16)) u_w4 (
      .clk(clk), .rst(rst), .start(st4), .ds(if4.slave), .busy(busy4),
      .result(res4), .best_index(bi4), .done(done4), .error(err4));
   p0008_stream #(.WINDOW(13), .RESULT_W(46), .IDX_W(16)) u_w13 (
      .clk(clk), .rst(rst), .start(st13), .ds(if13.slave), .busy(busy13),
      .result(res13), .best_index(bi13), .done(done13), .error(err13));
   p0008_stream #(.WINDOW(2), .RESULT_W(46), .IDX_W(16)) u_w2 (
      .clk(clk), .rst(rst), .start(st2), .ds(if2.slave), .busy(busy2),
      .result(res2), .best_index(bi2), .done(done2), .error(err2));

   logic        cur_ready, cur_busy, cur_done, cur_err;
   logic [45:0] cur_result;
   logic [15:0] cur_best;

   always_comb begin
      cur_ready  = if4.digit_ready;
      cur_busy   = busy4;
      cur_done   = done4;
      cur_err    = err4;
      cur_result = res4;
      cur_best   = bi4;
      if (sel == 1) begin
         cur_ready  = if13.digit_ready;
         cur_busy   = busy13;
         cur_done   = done13;
         cur_err    = err13;
         cur_result = res13;
         cur_best   = bi13;
      end else if (sel == 2) begin
         cur_ready  = if2.digit_ready;
         cur_busy   = busy2;
         cur_done   = done2;
         cur_err    = err2;
         cur_result = res2;
         cur_best   = bi2;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   int   t_start = 0;
   int   t_done = 0;

   string euler [20] = '{
      "73167176531330624919225119674426574742355349194934",
      "96983520312774506326239578318016984801869478851843",
      "85861560789112949495459501737958331952853208805511",
      "12540698747158523863050715693290963295227443043557",
      "66896648950445244523161731856403098711121722383113",
      "62229893423380308135336276614282806444486645238749",
      "30358907296290491560440772390713810515859307960866",
      "70172427121883998797908792274921901699720888093776",
      "65727333001053367881220235421809751254540594752243",
      "52584907711670556013604839586446706324415722155397",
      "53697817977846174064955149290862569321978468622482",
      "83972241375657056057490261407972968652414535100474",
      "82166370484403199890008895243450658541227588666881",
      "16427171479924442928230863465674813919123162824586",
      "17866458359124566529476545682848912883142607690042",
      "24219022671055626321111109370544217506941658960408",
      "07198403850962455444362981230987879927244284909188",
      "84580156166097919133875499200524063689912560717606",
      "05886116467109405077541002256983155200055935729725",
      "71636269561882670428252483600823257530420752963450"
   };

   task automatic check(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Reference: scans the series as a software loop over whole windows.
   function automatic exp_t model(input int q[$], input int w, input bit use_last);
      exp_t e;
      longint p;
      e.res = 0;
      e.idx = 0;
      e.err = 0;
      for (int k = 0; k < q.size(); k++) begin
         if (q[k] > 9) begin
            e.err = 1;
            break;
         end
         if (k >= w - 1) begin
            p = 1;
            for (int m = k - w + 1; m <= k; m++) p = p * q[m];
            if (p > e.res) begin
               e.res = p;
               e.idx = k - w + 1;
            end
         end else if (use_last && k == q.size() - 1) begin
            e.err = 1;
         end
      end
      return e;
   endfunction

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      t_start = cyc;
   endtask

   task automatic feed(input int q[$], input bit use_last, input int w);
      int gap;
      for (int k = 0; k < q.size(); k++) begin
         src_valid = 1'b1;
         src_digit = 4'(q[k]);
         src_last  = use_last && (k == q.size() - 1);
         gap = 0;
         @(negedge clk);
         while (!cur_ready && gap < 100) begin
            gap++;
            @(negedge clk);
         end
         if (!cur_ready) begin
            check("feed_timeout", 0, 1);
            src_valid = 1'b0;
            src_last  = 1'b0;
            return;
         end
         check($sformatf("ready_gap_k%0d", k), gap, (k >= w) ? w : 0);
         @(posedge clk);
         #1;
      end
      src_valid = 1'b0;
      src_last  = 1'b0;
   endtask

   task automatic wait_and_score(input string tag);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!cur_done && n < 20000) begin
         n++;
         @(negedge clk);
      end
      t_done = cyc;
      check({tag, "_done"}, cur_done, 1);
      check({tag, "_busy"}, cur_busy, 0);
      check({tag, "_ready"}, cur_ready, 0);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_result"}, cur_result, e.res);
         check({tag, "_best_index"}, cur_best, e.idx);
         check({tag, "_error"}, cur_err, e.err);
      end
   endtask

   task automatic run_series(input string tag, input int s, input int w,
                             input int q[$], input bit use_last);
      sel = s;
      exp_q.push_back(model(q, w, use_last));
      pulse_start();
      feed(q, use_last, w);
      wait_and_score(tag);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy4"}, busy4, 0);
      check({tag, "_ready4"}, if4.digit_ready, 0);
      check({tag, "_done4"}, done4, 0);
      check({tag, "_err4"}, err4, 0);
      check({tag, "_res4"}, res4, 0);
      check({tag, "_bi4"}, bi4, 0);
      check({tag, "_busy13"}, busy13, 0);
      check({tag, "_done2"}, done2, 0);
      check({tag, "_res13"}, res13, 0);
      check({tag, "_res2"}, res2, 0);
   endtask

   initial begin
      int q1[$] = '{1, 2, 3, 4, 5, 0, 9, 9};
      int q3[$] = '{7, 7, 10};
      int q4[$] = '{9, 9, 9};
      int q5[$] = '{2, 3, 1, 6};
      int q6[$] = '{1, 2, 3, 4};
      int qe[$];
      int qr[$];
      int lat;
      byte b;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("idle");

      run_series("t1", 0, 4, q1, 1'b1);
      check("t1_result_const", res4, 120);
      check("t1_index_const", bi4, 1);

      for (int r = 0; r < 20; r++) begin
         for (int c = 0; c < 50; c++) begin
            b = euler[r][c];
            qe.push_back(int'(b) - 48);
         end
      end
      run_series("t2", 1, 13, qe, 1'b1);
      check("t2_result_const", res13, 64'd23514624000);
      lat = t_done - t_start;
      check("t2_latency_within_2", (lat >= 13842 && lat <= 13846) ? 1 : 0, 1);
      if (lat < 13842 || lat > 13846) $display("t2 latency %0d cycles", lat);

      run_series("t3", 0, 4, q3, 1'b0);
      run_series("t3_recover", 0, 4, q1, 1'b1);

      run_series("t4", 0, 4, q4, 1'b1);

      run_series("t5", 2, 2, q5, 1'b1);
      check("t5_index_const", bi2, 0);

      for (int t = 0; t < 4; t++) begin
         int len;
         qr.delete();
         len = $urandom_range(6, 18);
         for (int k = 0; k < len; k++) qr.push_back($urandom_range(0, 9));
         run_series($sformatf("rand%0d", t), (t % 2 == 0) ? 0 : 2,
                    (t % 2 == 0) ? 4 : 2, qr, 1'b1);
      end

      // reset while the W4 engine is mid-multiply
      sel = 0;
      pulse_start();
      feed(q6, 1'b0, 4);
      check("t6_busy_in_mul", busy4, 1);
      check("t6_ready_in_mul", if4.digit_ready, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_all_zero("t6_rst");
      @(negedge clk);
      rst = 1'b0;
      run_series("t6_rerun", 0, 4, q1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
